// File: rtl/mem_arbiter_if.sv
// Signal bundle between the two requesters, the shared memory slave and the arbiter status.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface mem_arbiter_if #(
    parameter int unsigned ADDR_WIDTH = 15
);
    logic                  m0_valid;
    logic [31:0]           m0_addr;
    logic [31:0]           m0_wdata;
    logic [3:0]            m0_wstrb;
    logic [31:0]           m0_rdata;
    logic                  m0_ready;

    logic                  m1_valid;
    logic [31:0]           m1_addr;
    logic [31:0]           m1_wdata;
    logic [3:0]            m1_wstrb;
    logic [31:0]           m1_rdata;
    logic                  m1_ready;

    logic                  s_cs;
    logic [3:0]            s_we;
    logic [ADDR_WIDTH-1:0] s_address;
    logic [31:0]           s_write_data;
    logic [31:0]           s_read_data;
    logic                  s_ready;

    logic                  owner;
    logic                  busy;
    logic                  timeout_err;
    logic                  err_clear;

    modport slave (
        input  m0_valid, m0_addr, m0_wdata, m0_wstrb,
        output m0_rdata, m0_ready,
        input  m1_valid, m1_addr, m1_wdata, m1_wstrb,
        output m1_rdata, m1_ready,
        output s_cs, s_we, s_address, s_write_data,
        input  s_read_data, s_ready,
        output owner, busy, timeout_err,
        input  err_clear
    );

    modport master (
        output m0_valid, m0_addr, m0_wdata, m0_wstrb,
        input  m0_rdata, m0_ready,
        output m1_valid, m1_addr, m1_wdata, m1_wstrb,
        input  m1_rdata, m1_ready,
        input  s_cs, s_we, s_address, s_write_data,
        output s_read_data, s_ready,
        input  owner, busy, timeout_err,
        output err_clear
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter giving two valid/ready masters access to one single-ported memory slave,
// with a watchdog that aborts an access when the slave does not answer within TIMEOUT cycles.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 15,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_arbiter_if.slave bus
);
    localparam int unsigned   CNT_W    = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           wdata;
        logic [3:0]            wstrb;
    } req_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    state_e           state_q, state_d;
    req_t             req_q, req_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    req_t m0_req_c, m1_req_c;
    logic grant_c;
    logic in_access_c, in_resp_c;
    logic m0_sel_c, m1_sel_c;

    assign m0_req_c = '{addr: bus.m0_addr[ADDR_WIDTH+1:2], wdata: bus.m0_wdata, wstrb: bus.m0_wstrb};
    assign m1_req_c = '{addr: bus.m1_addr[ADDR_WIDTH+1:2], wdata: bus.m1_wdata, wstrb: bus.m1_wstrb};

    // On a tie the master not served last wins; otherwise whoever is requesting.
    assign grant_c = (bus.m0_valid & bus.m1_valid) ? ~last_q : bus.m1_valid;

    // Byte-offset and above-window address bits never reach the word-addressed slave.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.m0_addr[31:ADDR_WIDTH+2], bus.m0_addr[1:0],
                                bus.m1_addr[31:ADDR_WIDTH+2], bus.m1_addr[1:0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = bus.err_clear ? 1'b0 : err_q;

        unique case (state_q)
            IDLE: begin
                if (bus.m0_valid || bus.m1_valid) begin
                    owner_d = grant_c;
                    req_d   = grant_c ? m1_req_c : m0_req_c;
                    cnt_d   = '0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (bus.s_ready) begin
                    rdata_d = bus.s_read_data;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    // Watchdog abort: a timeout beats a simultaneous clear.
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = CNT_W'(cnt_q + CNT_W'(1));
                end
            end
            RESP: begin
                last_d  = owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_access_c = (state_q == ACCESS);
    assign in_resp_c   = (state_q == RESP);
    assign m0_sel_c    = in_resp_c & ~owner_q;
    assign m1_sel_c    = in_resp_c &  owner_q;

    assign bus.s_cs         = in_access_c;
    assign bus.s_we         = in_access_c ? req_q.wstrb : 4'h0;
    assign bus.s_address    = in_access_c ? req_q.addr  : '0;
    assign bus.s_write_data = in_access_c ? req_q.wdata : 32'h0;

    assign bus.m0_ready = m0_sel_c;
    assign bus.m0_rdata = m0_sel_c ? rdata_q : 32'h0;
    assign bus.m1_ready = m1_sel_c;
    assign bus.m1_rdata = m1_sel_c ? rdata_q : 32'h0;

    assign bus.owner       = owner_q;
    assign bus.busy        = in_access_c | in_resp_c;
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single reads/writes, wait states, watchdog abort,
// asynchronous reset mid-access and round-robin fairness, with TIMEOUT set to 4.
module tb_mem_arbiter;
    logic clk;
    logic reset_n;
    int   checks   = 0;
    int   failures = 0;

    mem_arbiter_if #(.ADDR_WIDTH(15)) bus ();

    mem_arbiter #(.ADDR_WIDTH(15), .TIMEOUT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n          = 1'b0;
        bus.m0_valid     = 1'b0;
        bus.m0_addr      = 32'h0;
        bus.m0_wdata     = 32'h0;
        bus.m0_wstrb     = 4'h0;
        bus.m1_valid     = 1'b0;
        bus.m1_addr      = 32'h0;
        bus.m1_wdata     = 32'h0;
        bus.m1_wstrb     = 4'h0;
        bus.s_read_data  = 32'h0;
        bus.s_ready      = 1'b0;
        bus.err_clear    = 1'b0;

        // Reset state
        #12;
        chk("rst_s_cs",  32'(bus.s_cs), 32'h0);
        chk("rst_busy",  32'(bus.busy), 32'h0);
        chk("rst_owner", 32'(bus.owner), 32'h0);
        chk("rst_m0_ready", 32'(bus.m0_ready), 32'h0);
        chk("rst_terr",  32'(bus.timeout_err), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        cyc();

        // m0 read, slave ready in first ACCESS cycle
        bus.m0_valid = 1'b1;
        bus.m0_addr  = 32'h4000_0008;
        bus.m0_wstrb = 4'h0;
        cyc();
        chk("rd_s_cs",   32'(bus.s_cs), 32'h1);
        chk("rd_s_addr", 32'(bus.s_address), 32'h2);
        chk("rd_s_we",   32'(bus.s_we), 32'h0);
        chk("rd_m0_ready_early", 32'(bus.m0_ready), 32'h0);
        bus.s_ready     = 1'b1;
        bus.s_read_data = 32'hDEAD_BEEF;
        cyc();
        chk("rd_m0_ready", 32'(bus.m0_ready), 32'h1);
        chk("rd_m0_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
        chk("rd_m1_ready", 32'(bus.m1_ready), 32'h0);
        chk("rd_m1_rdata", bus.m1_rdata, 32'h0);
        chk("rd_resp_cs",  32'(bus.s_cs), 32'h0);
        bus.m0_valid = 1'b0;
        bus.s_ready  = 1'b0;
        cyc();
        chk("rd_m0_ready_after", 32'(bus.m0_ready), 32'h0);
        chk("rd_idle_busy",      32'(bus.busy), 32'h0);

        // m1 write with two wait states; address change after grant is ignored
        bus.m1_valid = 1'b1;
        bus.m1_addr  = 32'h4000_0010;
        bus.m1_wdata = 32'h1234_5678;
        bus.m1_wstrb = 4'h3;
        cyc();
        bus.m1_addr  = 32'h4000_7FFC;
        bus.m1_wdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            chk("wr_s_cs",    32'(bus.s_cs), 32'h1);
            chk("wr_s_addr",  32'(bus.s_address), 32'h4);
            chk("wr_s_we",    32'(bus.s_we), 32'h3);
            chk("wr_s_wdata", bus.s_write_data, 32'h1234_5678);
            chk("wr_owner",   32'(bus.owner), 32'h1);
            if (i == 2) begin
                bus.s_ready     = 1'b1;
                bus.s_read_data = 32'h0000_5A5A;
            end
            cyc();
        end
        chk("wr_m1_ready", 32'(bus.m1_ready), 32'h1);
        chk("wr_m1_rdata", bus.m1_rdata, 32'h0000_5A5A);
        chk("wr_m0_ready", 32'(bus.m0_ready), 32'h0);
        chk("wr_resp_cs",  32'(bus.s_cs), 32'h0);
        chk("wr_resp_we",  32'(bus.s_we), 32'h0);
        bus.m1_valid = 1'b0;
        bus.s_ready  = 1'b0;
        cyc();
        chk("wr_m1_ready_after", 32'(bus.m1_ready), 32'h0);

        // Watchdog timeout, slave never ready
        bus.m0_valid    = 1'b1;
        bus.m0_addr     = 32'h4000_0000;
        bus.m0_wstrb    = 4'h0;
        bus.s_read_data = 32'hAAAA_5555;
        cyc();
        for (int i = 0; i < 4; i++) begin
            chk("to_s_cs", 32'(bus.s_cs), 32'h1);
            chk("to_terr_pre", 32'(bus.timeout_err), 32'h0);
            cyc();
        end
        chk("to_s_cs_end",  32'(bus.s_cs), 32'h0);
        chk("to_m0_ready",  32'(bus.m0_ready), 32'h1);
        chk("to_m0_rdata",  bus.m0_rdata, 32'h0);
        chk("to_terr",      32'(bus.timeout_err), 32'h1);
        bus.m0_valid = 1'b0;
        cyc();
        cyc();
        chk("to_terr_hold", 32'(bus.timeout_err), 32'h1);
        bus.err_clear = 1'b1;
        cyc();
        bus.err_clear = 1'b0;
        chk("to_terr_clr", 32'(bus.timeout_err), 32'h0);

        // Second timeout coincident with err_clear: set wins
        bus.m0_valid = 1'b1;
        cyc();
        cyc();
        cyc();
        cyc();
        chk("to2_s_cs_last", 32'(bus.s_cs), 32'h1);
        bus.err_clear = 1'b1;
        cyc();
        bus.err_clear = 1'b0;
        chk("to2_m0_ready", 32'(bus.m0_ready), 32'h1);
        chk("to2_terr",     32'(bus.timeout_err), 32'h1);
        bus.m0_valid = 1'b0;
        cyc();
        chk("to2_terr_hold", 32'(bus.timeout_err), 32'h1);

        // m0 drops valid while waiting; access still completes, no re-grant
        bus.err_clear = 1'b1;
        bus.m0_valid  = 1'b1;
        cyc();
        bus.err_clear = 1'b0;
        bus.m0_valid  = 1'b0;
        chk("drop_s_cs", 32'(bus.s_cs), 32'h1);
        cyc();
        chk("drop_s_cs_wait", 32'(bus.s_cs), 32'h1);
        bus.s_ready     = 1'b1;
        bus.s_read_data = 32'h0BAD_F00D;
        cyc();
        bus.s_ready = 1'b0;
        chk("drop_m0_ready", 32'(bus.m0_ready), 32'h1);
        chk("drop_m0_rdata", bus.m0_rdata, 32'h0BAD_F00D);
        cyc();
        chk("drop_idle_busy",  32'(bus.busy), 32'h0);
        chk("drop_m0_ready_0", 32'(bus.m0_ready), 32'h0);
        cyc();
        chk("drop_no_regrant", 32'(bus.busy), 32'h0);

        // Asynchronous reset in the second ACCESS cycle of an m1 access
        bus.m1_valid = 1'b1;
        bus.m1_addr  = 32'h4000_0020;
        bus.m1_wstrb = 4'h0;
        cyc();
        cyc();
        chk("ar_s_cs_pre",  32'(bus.s_cs), 32'h1);
        chk("ar_owner_pre", 32'(bus.owner), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_s_cs",     32'(bus.s_cs), 32'h0);
        chk("ar_busy",     32'(bus.busy), 32'h0);
        chk("ar_m1_ready", 32'(bus.m1_ready), 32'h0);
        chk("ar_owner",    32'(bus.owner), 32'h0);

        // Both masters held valid from reset release, zero-wait slave: strict alternation
        bus.m0_valid    = 1'b1;
        bus.m1_valid    = 1'b1;
        bus.s_ready     = 1'b1;
        bus.s_read_data = 32'h1111_0000;
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            chk("fair_busy",     32'(bus.busy),     32'((k % 3) != 0));
            chk("fair_m0_ready", 32'(bus.m0_ready), 32'((k % 6) == 2));
            chk("fair_m1_ready", 32'(bus.m1_ready), 32'((k % 6) == 5));
            if ((k % 3) == 1)
                chk("fair_owner", 32'(bus.owner), 32'(((k - 1) / 3) % 2));
            if ((k % 6) == 2)
                chk("fair_m0_rdata", bus.m0_rdata, 32'h1111_0000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
